fifo_flush_arbiter: RTL and testbench



---
 rtl/fifo_flush_pkg.sv | 18 +
 rtl/fifo_rr_arbiter.sv | 52 +++++
 rtl/fifo_flush_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_flush_arbiter.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flush_pkg.sv
// Shared types and constants for the FIFO flush arbiter slice.
package fifo_flush_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } flush_state_e;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_DEPTH  = 32;

    // Drain counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a registered pointer.
module fifo_rr_arbiter
    import fifo_flush_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    input  logic                       ptr_update,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    int unsigned      k;

    // First asserted request at or above the pointer, wrapping mod NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (enable && !found && req[IDX_W'(k)]) begin
                found                 = 1'b1;
                grant[IDX_W'(k)]      = 1'b1;
                grant_idx             = IDX_W'(k);
            end
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (ptr_update) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/fifo_flush_arbiter.sv
// Write arbiter and flush/drain controller in front of a flush-capable FIFO.
// Optional drain timeout enabled by defining FIFO_FLUSH_TIMEOUT_EN.
module fifo_flush_arbiter
    import fifo_flush_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        flush_req_i,
    output logic                        flush_busy_o,
    output logic                        flush_done_o,
    output logic [$clog2(DEPTH):0]      drained_count_o,
    output logic                        fifo_wr_valid_o,
    output logic [DATA_W-1:0]           fifo_wr_data_o,
    output logic                        fifo_rd_valid_o,
    input  logic                        fifo_full_i,
    input  logic                        fifo_empty_i
`ifdef FIFO_FLUSH_TIMEOUT_EN
    ,
    output logic                        flush_timeout_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    if (NUM_REQ < 2 || NUM_REQ > 8 || DRAIN_TIMEOUT < 1) begin : g_bad_param
        $error("fifo_flush_arbiter: NUM_REQ must be 2..8 and DRAIN_TIMEOUT >= 1");
    end

    flush_state_e       state_q;
    flush_state_e       state_d;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               wr_fire;
    logic               rd_fire;
    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt_q;

    // Writes are only granted in RUN, with space available and no flush pending.
    assign arb_en  = !reset && (state_q == ST_RUN) && !fifo_full_i && !flush_req_i;
    assign wr_fire = |(req_valid_i & grant);
    assign rd_fire = !reset && (state_q == ST_DRAIN) && !fifo_empty_i;

    fifo_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid_i),
        .enable     (arb_en),
        .ptr_update (wr_fire),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

`ifdef FIFO_FLUSH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [TO_W-1:0] drain_cyc_q;
    logic            timeout_q;

    // Fires on the last allowed drain cycle if the FIFO still holds data.
    assign timeout_hit = (state_q == ST_DRAIN) && !fifo_empty_i &&
                         (drain_cyc_q == TO_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cyc_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q != ST_DRAIN) begin
                drain_cyc_q <= '0;
            end else begin
                drain_cyc_q <= drain_cyc_q + TO_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush requests outside RUN are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_i || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic; everything is forced low while reset is asserted.
    always_comb begin
        req_ready_o     = '0;
        fifo_wr_valid_o = 1'b0;
        fifo_wr_data_o  = '0;
        fifo_rd_valid_o = 1'b0;
        flush_busy_o    = 1'b0;
        flush_done_o    = 1'b0;
`ifdef FIFO_FLUSH_TIMEOUT_EN
        flush_timeout_o = 1'b0;
`endif
        if (!reset) begin
            req_ready_o     = grant;
            fifo_wr_valid_o = wr_fire;
            fifo_rd_valid_o = rd_fire;
            flush_busy_o    = (state_q != ST_RUN);
            flush_done_o    = (state_q == ST_DONE);
`ifdef FIFO_FLUSH_TIMEOUT_EN
            flush_timeout_o = (state_q == ST_DONE) && timeout_q;
`endif
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (wr_fire && (grant_idx == IDX_W'(j))) begin
                    fifo_wr_data_o = DATA_W'(req_data_i >> (j * DATA_W));
                end
            end
        end
    end

    // Drained entry count: cleared when a flush starts, saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) begin
            cnt_q <= '0;
        end else if (rd_fire && (cnt_q != CNT_W'(DEPTH))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign drained_count_o = cnt_q;

endmodule

// File: tb/tb_fifo_flush_arbiter.sv
// Self-checking bench for fifo_flush_arbiter: directed scenarios plus a
// randomized run against a transaction-level model with an emulated FIFO.
module tb_fifo_flush_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 32;
    localparam int TMO   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*DW-1:0]   req_data_i = '0;
    logic [N-1:0]      req_ready_o;
    logic              flush_req_i = 1'b0;
    logic              flush_busy_o;
    logic              flush_done_o;
    logic [5:0]        drained_count_o;
    logic              fifo_wr_valid_o;
    logic [DW-1:0]     fifo_wr_data_o;
    logic              fifo_rd_valid_o;
    logic              fifo_full_i = 1'b0;
    logic              fifo_empty_i = 1'b1;
`ifdef FIFO_FLUSH_TIMEOUT_EN
    logic              flush_timeout_o;
`endif

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    int occ   = 0;

    fifo_flush_arbiter #(
        .NUM_REQ       (N),
        .DATA_W        (DW),
        .DEPTH         (DEPTH),
        .DRAIN_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .flush_req_i     (flush_req_i),
        .flush_busy_o    (flush_busy_o),
        .flush_done_o    (flush_done_o),
        .drained_count_o (drained_count_o),
        .fifo_wr_valid_o (fifo_wr_valid_o),
        .fifo_wr_data_o  (fifo_wr_data_o),
        .fifo_rd_valid_o (fifo_rd_valid_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_empty_i    (fifo_empty_i)
`ifdef FIFO_FLUSH_TIMEOUT_EN
        ,
        .flush_timeout_o (flush_timeout_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin winner: first valid index scanning upward from ptr.
    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (((v >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] nib(input logic [N*DW-1:0] d, input int g);
        return DW'(d >> (g * DW));
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r = N'(1) << g;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_i = '1;
        req_data_i = 16'($urandom);
        flush_req_i = 1'b1;
        fifo_empty_i = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0 || fifo_wr_valid_o !== 1'b0 || fifo_wr_data_o !== 4'b0) begin
            fails++;
            $display("FAIL reset_wr: ready=%b wv=%b wd=%h required 0/0/0", req_ready_o, fifo_wr_valid_o, fifo_wr_data_o);
        end
        tests++;
        if (fifo_rd_valid_o !== 1'b0 || flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush: rd=%b busy=%b done=%b required 0/0/0", fifo_rd_valid_o, flush_busy_o, flush_done_o);
        end
        next_cycle();
        reset = 1'b0;
        flush_req_i = 1'b0;
        req_valid_i = '0;
        fifo_empty_i = 1'b1;
        @(negedge clk);
        tests++;
        if (drained_count_o !== 6'd0 || flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: count=%0d busy=%b done=%b required 0/0/0", drained_count_o, flush_busy_o, flush_done_o);
        end
        next_cycle();
        m_ptr = 0;
    endtask

    task automatic test_rotation();
        for (int c = 0; c < 8; c++) begin
            req_valid_i = '1;
            req_data_i = 16'($urandom);
            @(negedge clk);
            tests++;
            if (req_ready_o !== onehot(c % N) || fifo_wr_valid_o !== 1'b1 ||
                fifo_wr_data_o !== nib(req_data_i, c % N)) begin
                fails++;
                $display("FAIL rotation c=%0d: ready=%b wv=%b wd=%h required %b/1/%h",
                         c, req_ready_o, fifo_wr_valid_o, fifo_wr_data_o, onehot(c % N), nib(req_data_i, c % N));
            end
            next_cycle();
        end
        m_ptr = 0;
        req_valid_i = '0;
    endtask

    task automatic test_single_req();
        int seq [4] = '{0, 2, 0, 2};
        for (int c = 0; c < 4; c++) begin
            req_valid_i = 4'b0100;
            req_data_i = 16'($urandom);
            @(negedge clk);
            tests++;
            if (req_ready_o !== 4'b0100 || fifo_wr_data_o !== nib(req_data_i, 2)) begin
                fails++;
                $display("FAIL single_req c=%0d: ready=%b wd=%h required 0100/%h", c, req_ready_o, fifo_wr_data_o, nib(req_data_i, 2));
            end
            next_cycle();
        end
        m_ptr = 3;
        for (int c = 0; c < 4; c++) begin
            req_valid_i = 4'b0101;
            req_data_i = 16'($urandom);
            @(negedge clk);
            tests++;
            if (req_ready_o !== onehot(seq[c]) || fifo_wr_data_o !== nib(req_data_i, seq[c])) begin
                fails++;
                $display("FAIL two_req c=%0d: ready=%b wd=%h required %b/%h", c, req_ready_o, fifo_wr_data_o, onehot(seq[c]), nib(req_data_i, seq[c]));
            end
            next_cycle();
        end
        m_ptr = 3;
        req_valid_i = '0;
    endtask

    task automatic test_full();
        int seq [2] = '{3, 0};
        req_valid_i = '1;
        fifo_full_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready_o !== 4'b0 || fifo_wr_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL full c=%0d: ready=%b wv=%b required 0/0", c, req_ready_o, fifo_wr_valid_o);
            end
            next_cycle();
        end
        fifo_full_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready_o !== onehot(seq[c]) || fifo_wr_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL full_resume c=%0d: ready=%b wv=%b required %b/1", c, req_ready_o, fifo_wr_valid_o, onehot(seq[c]));
            end
            next_cycle();
        end
        m_ptr = 1;
        req_valid_i = '0;
    endtask

    task automatic test_flush_drain();
        int reads = 0;
        int drain_cycles = 0;
        bit seen_done = 0;
        occ = 5;
        req_valid_i = '1;
        flush_req_i = 1'b1;
        fifo_empty_i = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0 || fifo_wr_valid_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_start: ready=%b wv=%b busy=%b required 0/0/0", req_ready_o, fifo_wr_valid_o, flush_busy_o);
        end
        next_cycle();
        flush_req_i = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            fifo_empty_i = (occ == 0);
            @(negedge clk);
            if (flush_done_o === 1'b1) begin
                seen_done = 1;
                tests++;
                if (drained_count_o !== 6'd5 || fifo_rd_valid_o !== 1'b0 || flush_busy_o !== 1'b1) begin
                    fails++;
                    $display("FAIL flush_done_state: count=%0d rd=%b busy=%b required 5/0/1", drained_count_o, fifo_rd_valid_o, flush_busy_o);
                end
            end else begin
                drain_cycles++;
                tests++;
                if (req_ready_o !== 4'b0 || flush_busy_o !== 1'b1 || fifo_rd_valid_o !== (occ > 0)) begin
                    fails++;
                    $display("FAIL drain c=%0d: ready=%b busy=%b rd=%b required 0/1/%b", c, req_ready_o, flush_busy_o, fifo_rd_valid_o, occ > 0);
                end
                if (fifo_rd_valid_o === 1'b1) begin
                    reads++;
                    if (occ > 0) occ--;
                end
            end
            next_cycle();
        end
        tests++;
        if (!seen_done || reads != 5 || drain_cycles != 6) begin
            fails++;
            $display("FAIL flush_totals: done_seen=%0d reads=%0d drain_cycles=%0d required 1/5/6", seen_done, reads, drain_cycles);
        end
        fifo_empty_i = 1'b1;
        @(negedge clk);
        tests++;
        if (flush_done_o !== 1'b0 || flush_busy_o !== 1'b0 || drained_count_o !== 6'd5 || req_ready_o !== onehot(exp_grant('1, m_ptr))) begin
            fails++;
            $display("FAIL flush_after: done=%b busy=%b count=%0d ready=%b required 0/0/5/%b",
                     flush_done_o, flush_busy_o, drained_count_o, req_ready_o, onehot(exp_grant('1, m_ptr)));
        end
        next_cycle();
        m_ptr = (exp_grant('1, m_ptr) + 1) % N;
        req_valid_i = '0;
    endtask

    task automatic test_flush_empty();
        fifo_empty_i = 1'b1;
        flush_req_i = 1'b1;
        @(negedge clk);
        next_cycle();
        flush_req_i = 1'b0;
        @(negedge clk);
        tests++;
        if (flush_busy_o !== 1'b1 || flush_done_o !== 1'b0 || fifo_rd_valid_o !== 1'b0 || drained_count_o !== 6'd0) begin
            fails++;
            $display("FAIL empty_drain: busy=%b done=%b rd=%b count=%0d required 1/0/0/0", flush_busy_o, flush_done_o, fifo_rd_valid_o, drained_count_o);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (flush_done_o !== 1'b1 || drained_count_o !== 6'd0) begin
            fails++;
            $display("FAIL empty_done: done=%b count=%0d required 1/0", flush_done_o, drained_count_o);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if (flush_done_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL empty_after: done=%b busy=%b required 0/0", flush_done_o, flush_busy_o);
        end
        next_cycle();
    endtask

    task automatic test_level_flush();
        bit exp_busy [5] = '{0, 1, 1, 0, 1};
        bit exp_done [5] = '{0, 0, 1, 0, 0};
        fifo_empty_i = 1'b1;
        flush_req_i = 1'b1;
        req_valid_i = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (flush_busy_o !== exp_busy[c] || flush_done_o !== exp_done[c] || req_ready_o !== 4'b0) begin
                fails++;
                $display("FAIL level_flush c=%0d: busy=%b done=%b ready=%b required %b/%b/0000",
                         c, flush_busy_o, flush_done_o, req_ready_o, exp_busy[c], exp_done[c]);
            end
            next_cycle();
        end
        flush_req_i = 1'b0;
        req_valid_i = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (flush_busy_o === 1'b0) break;
            next_cycle();
        end
        tests++;
        if (flush_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL level_exit: busy=%b required 0", flush_busy_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_drain();
        bit bad = 0;
        occ = 10;
        fifo_empty_i = 1'b0;
        flush_req_i = 1'b1;
        next_cycle();
        flush_req_i = 1'b0;
        for (int c = 0; c < 3; c++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (fifo_rd_valid_o !== 1'b0 || flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_comb: rd=%b busy=%b done=%b required 0/0/0", fifo_rd_valid_o, flush_busy_o, flush_done_o);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (flush_busy_o !== 1'b0 || drained_count_o !== 6'd0 || flush_done_o !== 1'b0 || fifo_rd_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: busy=%b count=%0d done=%b rd=%b required 0/0/0/0",
                     flush_busy_o, drained_count_o, flush_done_o, fifo_rd_valid_o);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            if (flush_done_o !== 1'b0 || flush_busy_o !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL mid_reset_nodone: done or busy seen after reset, required 0");
        end
        next_cycle();
        req_valid_i = '1;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 4'b0001) begin
            fails++;
            $display("FAIL mid_reset_ptr: ready=%b required 0001", req_ready_o);
        end
        next_cycle();
        m_ptr = 1;
        req_valid_i = '0;
        occ = 0;
        fifo_empty_i = 1'b1;
    endtask

    task automatic test_random();
        int phase = 0;
        int m_cnt = 0;
        int g;
        logic [N-1:0]  e_ready;
        logic [DW-1:0] e_data;
        bit e_rd;
        bit e_busy;
        bit e_done;
        for (int c = 0; c < 300; c++) begin
            req_valid_i = N'($urandom);
            req_data_i = 16'($urandom);
            fifo_full_i = (occ >= DEPTH) || ($urandom_range(0, 9) == 0);
            fifo_empty_i = (occ == 0);
            flush_req_i = (phase == 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
            g = -1;
            if (phase == 0 && !fifo_full_i && !flush_req_i) g = exp_grant(req_valid_i, m_ptr);
            e_ready = onehot(g);
            e_data = (g >= 0) ? nib(req_data_i, g) : '0;
            e_rd = (phase == 1) && (occ > 0);
            e_busy = (phase != 0);
            e_done = (phase == 2);
            @(negedge clk);
            tests++;
            if (req_ready_o !== e_ready || fifo_wr_valid_o !== (g >= 0) || fifo_wr_data_o !== e_data) begin
                fails++;
                $display("FAIL rand_wr c=%0d: ready=%b wv=%b wd=%h required %b/%b/%h",
                         c, req_ready_o, fifo_wr_valid_o, fifo_wr_data_o, e_ready, g >= 0, e_data);
            end
            tests++;
            if (fifo_rd_valid_o !== e_rd || flush_busy_o !== e_busy || flush_done_o !== e_done ||
                drained_count_o !== 6'(m_cnt)) begin
                fails++;
                $display("FAIL rand_flush c=%0d: rd=%b busy=%b done=%b count=%0d required %b/%b/%b/%0d",
                         c, fifo_rd_valid_o, flush_busy_o, flush_done_o, drained_count_o, e_rd, e_busy, e_done, m_cnt);
            end
            case (phase)
                0: begin
                    if (g >= 0) begin
                        m_ptr = (g + 1) % N;
                        occ++;
                    end
                    if (flush_req_i) begin
                        phase = 1;
                        m_cnt = 0;
                    end
                end
                1: begin
                    if (occ > 0) begin
                        occ--;
                        if (m_cnt < DEPTH) m_cnt++;
                    end else begin
                        phase = 2;
                    end
                end
                default: phase = 0;
            endcase
            next_cycle();
        end
        req_valid_i = '0;
        flush_req_i = 1'b0;
        fifo_full_i = 1'b0;
        for (int c = 0; c < 40 && phase != 0; c++) begin
            fifo_empty_i = (occ == 0);
            if (phase == 1 && occ > 0) occ--;
            else if (phase == 1) phase = 2;
            else phase = 0;
            next_cycle();
        end
        occ = 0;
        fifo_empty_i = 1'b1;
        next_cycle();
    endtask

`ifdef FIFO_FLUSH_TIMEOUT_EN
    task automatic test_timeout();
        int drain_cycles = 0;
        bit seen_done = 0;
        bit early_to = 0;
        fifo_empty_i = 1'b0;
        flush_req_i = 1'b1;
        next_cycle();
        flush_req_i = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            if (flush_done_o === 1'b1) begin
                seen_done = 1;
                tests++;
                if (flush_timeout_o !== 1'b1 || drained_count_o !== 6'(DEPTH)) begin
                    fails++;
                    $display("FAIL timeout_done: to=%b count=%0d required 1/%0d", flush_timeout_o, drained_count_o, DEPTH);
                end
            end else begin
                drain_cycles++;
                if (flush_timeout_o !== 1'b0) early_to = 1;
            end
            next_cycle();
        end
        tests++;
        if (!seen_done || drain_cycles != TMO || early_to) begin
            fails++;
            $display("FAIL timeout_len: done_seen=%0d drain_cycles=%0d early=%0d required 1/%0d/0", seen_done, drain_cycles, early_to, TMO);
        end
        @(negedge clk);
        tests++;
        if (flush_timeout_o !== 1'b0 || flush_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: to=%b busy=%b required 0/0", flush_timeout_o, flush_busy_o);
        end
        fifo_empty_i = 1'b1;
        next_cycle();
    endtask
`endif

    initial begin
        next_cycle();
        test_reset();
        test_rotation();
        test_single_req();
        test_full();
        test_flush_drain();
        test_flush_empty();
        test_level_flush();
        test_reset_mid_drain();
        test_random();
`ifdef FIFO_FLUSH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
